// File: rtl/l2_flush_seq.sv
// L2 flush sequencer: walks every set/way and evicts qualifying lines while
// limiting how many evictions are outstanding, then waits for every ack.
module l2_flush_seq #(
    parameter int SET_BITS = 9,
    parameter int WAY_BITS = 3,
    parameter int MAX_OUT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_valid,
    output logic                flush_ready,
    input  logic                flush_all,
    input  logic                stall,
    output logic                lmem_rd_en,
    output logic [SET_BITS-1:0] lmem_set,
    output logic [WAY_BITS-1:0] lmem_way,
    input  logic                lmem_line_valid,
    input  logic                lmem_dirty,
    input  logic                lmem_hprot,
    output logic                evict_valid,
    input  logic                evict_ready,
    output logic [SET_BITS-1:0] evict_set,
    output logic [WAY_BITS-1:0] evict_way,
    output logic                evict_dirty,
    input  logic                ack_valid,
    output logic                inv_wr_en,
    output logic                busy,
    output logic                flush_done,
    output logic                ack_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef enum logic [2:0] {IDLE, READ, CHECK, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    state_t              adv_state;
    logic [SET_BITS-1:0] set_idx;
    logic [WAY_BITS-1:0] way_idx;
    logic [CNT_W-1:0]    outstanding;
    logic                all_lat;
    logic                dirty_lat;
    logic                err;
    logic                accept;
    logic                qualify;
    logic                issue_ok;
    logic                handshake;
    logic                advance;
    logic                last_line;

    assign accept    = (state == IDLE) && flush_valid;
    assign qualify   = lmem_line_valid && (all_lat || lmem_hprot);
    // Once raised, evict_valid cannot drop: outstanding only grows on a handshake.
    assign issue_ok  = (state == ISSUE) && (outstanding < MAX_CNT);
    assign handshake = issue_ok && evict_ready;
    assign last_line = (&set_idx) && (&way_idx);
    assign advance   = ((state == CHECK) && !qualify) || handshake;
    assign adv_state = last_line ? DRAIN : READ;

    assign flush_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign evict_valid = issue_ok;
    assign inv_wr_en   = handshake;
    assign lmem_set    = set_idx;
    assign lmem_way    = way_idx;
    assign evict_set   = set_idx;
    assign evict_way   = way_idx;
    assign evict_dirty = dirty_lat;
    assign ack_err     = err;

    always_comb begin
        state_nxt  = state;
        lmem_rd_en = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE:  if (flush_valid) state_nxt = READ;
            READ: begin
                if (!stall) begin
                    lmem_rd_en = 1'b1;
                    state_nxt  = CHECK;
                end
            end
            CHECK: state_nxt = qualify ? ISSUE : adv_state;
            ISSUE: if (handshake) state_nxt = adv_state;
            DRAIN: if (outstanding == '0) state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            set_idx     <= '0;
            way_idx     <= '0;
            outstanding <= '0;
            all_lat     <= 1'b0;
            dirty_lat   <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                all_lat <= flush_all;
                set_idx <= '0;
                way_idx <= '0;
            end else if (advance) begin
                // Way is the inner index; both wrap to zero after the last line.
                way_idx <= way_idx + WAY_BITS'(1);
                if (&way_idx) set_idx <= set_idx + SET_BITS'(1);
            end
            if ((state == CHECK) && qualify) dirty_lat <= lmem_dirty;
            if (handshake && !ack_valid) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (ack_valid && !handshake && (outstanding != '0)) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (ack_valid && (outstanding == '0)) err <= 1'b1;
            else if (accept)                      err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_flush_seq.sv
// Randomized scoreboard bench for l2_flush_seq on a 2-set x 2-way cache with
// at most two evictions in flight; a negedge monitor checks against a line model.
module tb_l2_flush_seq;

    localparam int SB = 1;
    localparam int WB = 1;
    localparam int MO = 2;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_valid = 1'b0;
    logic          flush_ready;
    logic          flush_all = 1'b0;
    logic          stall = 1'b0;
    logic          lmem_rd_en;
    logic [SB-1:0] lmem_set;
    logic [WB-1:0] lmem_way;
    logic          lmem_line_valid = 1'b0;
    logic          lmem_dirty = 1'b0;
    logic          lmem_hprot = 1'b0;
    logic          evict_valid;
    logic          evict_ready = 1'b1;
    logic [SB-1:0] evict_set;
    logic [WB-1:0] evict_way;
    logic          evict_dirty;
    logic          ack_valid = 1'b0;
    logic          inv_wr_en;
    logic          busy;
    logic          flush_done;
    logic          ack_err;

    l2_flush_seq #(.SET_BITS(SB), .WAY_BITS(WB), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_all(flush_all), .stall(stall), .lmem_rd_en(lmem_rd_en),
        .lmem_set(lmem_set), .lmem_way(lmem_way), .lmem_line_valid(lmem_line_valid),
        .lmem_dirty(lmem_dirty), .lmem_hprot(lmem_hprot), .evict_valid(evict_valid),
        .evict_ready(evict_ready), .evict_set(evict_set), .evict_way(evict_way),
        .evict_dirty(evict_dirty), .ack_valid(ack_valid), .inv_wr_en(inv_wr_en),
        .busy(busy), .flush_done(flush_done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // line contents, indexed by set*2^WB + way
    bit mem_v[NL];
    bit mem_d[NL];
    bit mem_h[NL];

    int exp_q[$];
    int ack_due[$];

    // environment controls (changed by the main sequence on negedges)
    int ready_mode = 0;
    bit rand_stall = 1'b0;
    bit stall_force = 1'b0;
    bit auto_ack = 1'b1;
    int ack_dly = 0;
    int man_req = 0;
    int man_done = 0;

    // monitor state
    int ncyc = 0;
    bit rd_req = 1'b0;
    int rd_idx = 0;
    int exp_rd = 0;
    int mdl_out = 0;
    bit mdl_err = 1'b0;
    bit expect_accept = 1'b0;
    bit acc_seen = 1'b0;
    int acc_cyc = 0;
    bit done_seen = 1'b0;
    int done_cyc = 0;
    int hs_cnt = 0;
    int inv_cnt = 0;
    int ev_cnt = 0;
    bit pend = 1'b0;
    int pend_val = 0;
    bit prev_done = 1'b0;
    int last_due = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Monitor / scoreboard: everything sampled on the falling edge.
    initial begin
        bit hs;
        bit ack_zero;
        int act;
        int d;
        forever begin
            @(negedge clk);
            ncyc++;
            rd_req = lmem_rd_en;
            rd_idx = int'({lmem_set, lmem_way});
            if (rst) begin
                exp_q.delete();
                mdl_out = 0;
                mdl_err = 1'b0;
                pend = 1'b0;
                prev_done = 1'b0;
                continue;
            end
            hs = evict_valid && evict_ready;
            chk("ack_err", int'(ack_err), int'(mdl_err));
            if (flush_valid) begin
                if (expect_accept) begin
                    if (flush_ready) begin
                        expect_accept = 1'b0;
                        acc_seen = 1'b1;
                        acc_cyc = ncyc;
                        exp_rd = 0;
                    end
                end else begin
                    chk("ready_while_busy", int'(flush_ready), 0);
                end
            end
            if (lmem_rd_en) begin
                chk("rd_under_stall", int'(stall), 0);
                chk("rd_addr", rd_idx, exp_rd);
                exp_rd++;
            end
            if (evict_valid) begin
                ev_cnt++;
                chk("evict_limit", int'(mdl_out < MO), 1);
            end
            if (pend) begin
                chk("evict_hold", int'(evict_valid), 1);
                chk("evict_stable", int'({evict_set, evict_way, evict_dirty}), pend_val);
            end
            if (inv_wr_en) inv_cnt++;
            if (hs) begin
                hs_cnt++;
                act = int'({evict_set, evict_way, evict_dirty});
                if (exp_q.size() == 0) chk("unexpected_evict", act, -1);
                else chk("evict_line", act, exp_q.pop_front());
                chk("inv_on_hs", int'(inv_wr_en), 1);
                if (auto_ack) begin
                    d = (ack_dly > 0) ? ack_dly : $urandom_range(1, 4);
                    if (ncyc + d <= last_due) last_due = last_due + 1;
                    else last_due = ncyc + d;
                    ack_due.push_back(last_due);
                end
            end else if (inv_wr_en) begin
                chk("inv_without_hs", int'(inv_wr_en), 0);
            end
            pend = evict_valid && !evict_ready;
            pend_val = int'({evict_set, evict_way, evict_dirty});
            if (flush_done) begin
                chk("done_pulse_once", int'(prev_done), 0);
                chk("done_evicts_left", exp_q.size(), 0);
                chk("done_acks_left", mdl_out, 0);
                chk("done_lines_read", exp_rd, NL);
                done_seen = 1'b1;
                done_cyc = ncyc;
            end
            prev_done = flush_done;
            ack_zero = ack_valid && (mdl_out == 0);
            if (hs && !ack_valid) mdl_out++;
            else if (ack_valid && !hs && mdl_out > 0) mdl_out--;
            if (acc_seen && acc_cyc == ncyc) mdl_err = 1'b0;
            if (ack_zero) mdl_err = 1'b1;
        end
    end

    // Environment: memory responses, evict_ready, stall and acks, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ack_due.delete();
                ack_valid = 1'b0;
                continue;
            end
            if (rd_req) begin
                lmem_line_valid = mem_v[rd_idx];
                lmem_dirty      = mem_d[rd_idx];
                lmem_hprot      = mem_h[rd_idx];
            end else begin
                lmem_line_valid = 1'($urandom_range(0, 1));
                lmem_dirty      = 1'($urandom_range(0, 1));
                lmem_hprot      = 1'($urandom_range(0, 1));
            end
            if (ready_mode == 0)      evict_ready = 1'b1;
            else if (ready_mode == 1) evict_ready = 1'b0;
            else                      evict_ready = 1'($urandom_range(0, 1));
            stall = stall_force || (rand_stall && ($urandom_range(0, 3) == 0));
            ack_valid = 1'b0;
            if (man_req != man_done) begin
                ack_valid = 1'b1;
                man_done++;
            end else if (ack_due.size() > 0 && ack_due[0] <= ncyc + 1) begin
                ack_valid = 1'b1;
                void'(ack_due.pop_front());
            end
        end
    end

    task automatic start_flush(input bit all, input int hold);
        int b;
        for (int i = 0; i < NL; i++)
            if (mem_v[i] && (all || mem_h[i])) exp_q.push_back((i << 1) | int'(mem_d[i]));
        @(posedge clk);
        #1;
        acc_seen = 1'b0;
        done_seen = 1'b0;
        flush_all = all;
        expect_accept = 1'b1;
        flush_valid = 1'b1;
        b = 0;
        while (!acc_seen && b < 20) begin
            @(posedge clk);
            b++;
        end
        #1;
        if (!acc_seen) fail_now("accept_timeout");
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        flush_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while (!done_seen && b < budget) begin
            @(posedge clk);
            b++;
        end
        #1;
        if (!done_seen) fail_now("done_timeout");
    endtask

    task automatic wait_hs(input int target, input int budget);
        int b = 0;
        while (hs_cnt < target && b < budget) begin
            @(posedge clk);
            b++;
        end
        #1;
        if (hs_cnt < target) fail_now("handshake_timeout");
    endtask

    task automatic do_ack();
        @(negedge clk);
        man_req++;
    endtask

    task automatic set_mem(input int v, input int d, input int h);
        for (int i = 0; i < NL; i++) begin
            mem_v[i] = bit'((v >> i) & 1);
            mem_d[i] = bit'((d >> i) & 1);
            mem_h[i] = bit'((h >> i) & 1);
        end
    endtask

    initial begin
        int hs0;
        int inv0;
        int ev0;
        int b;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int inv0;
        int ev0;
        int b;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_flush_ready", int'(flush_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_evict_valid", int'(evict_valid), 0);
        chk("rst_rd_en", int'(lmem_rd_en), 0);
        chk("rst_inv", int'(inv_wr_en), 0);
        chk("rst_done", int'(flush_done), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_set_way", int'({lmem_set, lmem_way, evict_dirty}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // stray ack while idle and nothing outstanding
        do_ack();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_err", int'(ack_err), 1);

        // data-only flush: (0,0) dirty data line evicted, (1,1) instruction line skipped
        @(negedge clk);
        ack_dly = 3;
        set_mem(4'b1001, 4'b0001, 4'b0001);
        hs0 = hs_cnt;
        inv0 = inv_cnt;
        start_flush(1'b0, 2);
        chk("accept_clears_err", int'(ack_err), 0);
        wait_done(100);
        chk("data_flush_evicts", hs_cnt - hs0, 1);
        chk("data_flush_invs", inv_cnt - inv0, 1);

        // all lines invalid: fixed walk latency, no evictions
        set_mem(0, 4'b1111, 4'b1111);
        ev0 = ev_cnt;
        start_flush(1'b1, 0);
        wait_done(100);
        chk("empty_latency", done_cyc - acc_cyc, 10);
        chk("empty_evict_valid", ev_cnt - ev0, 0);
        chk("idle_after_done", int'(busy), 0);

        // five stalled cycles in the first READ delay completion by five
        @(negedge clk);
        stall_force = 1'b1;
        start_flush(1'b1, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        stall_force = 1'b0;
        wait_done(100);
        chk("stall_latency", done_cyc - acc_cyc, 15);

        // outstanding limit: two evictions then back-pressure until an ack
        @(negedge clk);
        auto_ack = 1'b0;
        set_mem(4'b1111, 4'b0101, 4'b0011);
        hs0 = hs_cnt;
        start_flush(1'b1, 0);
        wait_hs(hs0 + 2, 40);
        repeat (6) @(posedge clk);
        #1;
        chk("limit_hs", hs_cnt - hs0, 2);
        chk("limit_evict_valid", int'(evict_valid), 0);
        do_ack();
        wait_hs(hs0 + 3, 20);
        chk("third_after_ack", hs_cnt - hs0, 3);
        do_ack();
        wait_hs(hs0 + 4, 20);
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_before_acks", int'(done_seen), 0);
        do_ack();
        do_ack();
        wait_done(40);

        // randomized flushes
        @(negedge clk);
        auto_ack = 1'b1;
        ack_dly = 0;
        ready_mode = 2;
        rand_stall = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NL; i++) begin
                mem_v[i] = 1'($urandom_range(0, 1));
                mem_d[i] = 1'($urandom_range(0, 1));
                mem_h[i] = 1'($urandom_range(0, 1));
            end
            start_flush(1'($urandom_range(0, 1)), $urandom_range(0, 3));
            wait_done(400);
        end

        // reset in the middle of ISSUE with one eviction outstanding
        @(negedge clk);
        rand_stall = 1'b0;
        ready_mode = 0;
        auto_ack = 1'b0;
        set_mem(4'b1111, 4'b1111, 4'b1111);
        hs0 = hs_cnt;
        start_flush(1'b1, 0);
        wait_hs(hs0 + 1, 20);
        @(negedge clk);
        ready_mode = 1;
        b = 0;
        while (!evict_valid && b < 20) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (!evict_valid) fail_now("issue_timeout");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_evict_valid", int'(evict_valid), 0);
        chk("async_rst_ready", int'(flush_ready), 1);
        @(negedge clk);
        chk("rst_cycle_busy", int'(busy), 0);
        chk("rst_cycle_evict_valid", int'(evict_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("no_resume_busy", int'(busy), 0);
            chk("no_resume_rd", int'(lmem_rd_en), 0);
        end
        chk("post_rst_ack_err", int'(ack_err), 0);
        do_ack();
        repeat (3) @(posedge clk);
        #1;
        chk("outstanding_cleared", int'(ack_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_flush_seq.md
L2_FLUSH_SEQ -- requirements
Module: l2_flush_seq

Interface
REQ-001 SHALL have parameter SET_BITS, default 9: set index width; the sequencer walks 2^SET_BITS sets.
REQ-002 SHALL have parameter WAY_BITS, default 3: way index width; the sequencer walks 2^WAY_BITS ways per set.
REQ-003 SHALL have parameter MAX_OUT, default 4, legal range 1..15: maximum evictions issued but not yet acked.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as follows.
  - clk: input, 1 bit, clock; all state changes on rising edge.
  - rst: input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have these ports:
  - flush_valid  in  1  flush request.
  - flush_ready  out  1  request accepted this cycle.
  - flush_all  in  1  1 = all valid lines; 0 = only lines with hprot=1 (data).
  - stall  in  1  set-conflict/MSHR stall; blocks new reads.
  - lmem_rd_en  out  1  tag/state read strobe.
  - lmem_set  out  SET_BITS  read set index.
  - lmem_way  out  WAY_BITS  read way index.
  - lmem_line_valid  in  1  line valid; returned 1 cycle after lmem_rd_en.
  - lmem_dirty  in  1  line dirty; same timing as lmem_line_valid.
  - lmem_hprot  in  1  1 = data line; same timing as lmem_line_valid.
  - evict_valid  out  1  eviction request.
  - evict_ready  in  1  eviction accepted.
  - evict_set  out  SET_BITS  set index of the eviction.
  - evict_way  out  WAY_BITS  way index of the eviction.
  - evict_dirty  out  1  1 = put with data; 0 = put without data.
  - ack_valid  in  1  one eviction acknowledged.
  - inv_wr_en  out  1  invalidate the line at evict_set/evict_way.
  - busy  out  1  sequencer not in IDLE.
  - flush_done  out  1  single-cycle completion pulse.
  - ack_err  out  1  sticky: ack received while outstanding count = 0.

Function
REQ-006 SHALL use a state machine with states IDLE, READ, CHECK, ISSUE, DRAIN, DONE.
REQ-007 IDLE SHALL drive flush_ready=1.
  - On flush_valid: latch flush_all, set=0, way=0, clear ack_err, go to READ.
REQ-008 READ SHALL hold while stall=1.
  - When stall=0: assert lmem_rd_en for one cycle with the current set/way, go to CHECK.
REQ-009 CHECK SHALL sample the lmem inputs.
  - Line qualifies when valid AND (latched flush_all OR hprot).
  - Qualifying: latch dirty, go to ISSUE.
  - Not qualifying: advance per REQ-012.
REQ-010 ISSUE SHALL assert evict_valid only while outstanding < MAX_OUT.
  - evict_set/way/dirty SHALL stay stable until the handshake.
  - Dropping evict_valid once asserted is allowed only through reset.
REQ-011 On evict_valid AND evict_ready, the same cycle SHALL:
  - pulse inv_wr_en;
  - increment outstanding;
  - advance per REQ-012.
REQ-012 Advance SHALL step through the lines as follows.
  - Way is the inner index; at the last way it wraps to 0 and set increments.
  - After set=2^SET_BITS-1 with way=2^WAY_BITS-1, go to DRAIN.
  - Otherwise go to READ.
REQ-013 Outstanding counter SHALL be ceil(log2(MAX_OUT+1)) bits.
  - ack_valid decrements it.
  - Simultaneous handshake and ack leaves it unchanged.
  - ack_valid at 0 leaves it at 0 and sets ack_err.
REQ-014 ack_valid SHALL be honoured in every state, including IDLE.
REQ-015 DRAIN SHALL go to DONE on the first cycle outstanding = 0.
REQ-016 DONE SHALL assert flush_done for exactly one cycle, then go to IDLE.
REQ-017 A flush_valid arriving while not in IDLE SHALL be ignored (flush_ready=0).
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 A full walk with no stalls and no qualifying lines SHALL take 2*2^(SET_BITS+WAY_BITS)+2 cycles from acceptance to flush_done.

Reset
REQ-020 Asserting rst SHALL force, asynchronously and at any point including mid-walk:
  - state=IDLE;
  - set, way, outstanding = 0;
  - ack_err = 0;
  - flush_ready=1;
  - all other outputs = 0.
REQ-021 After rst deasserts, the interrupted walk SHALL NOT resume; a new flush_valid is required.

Verification
REQ-022 SET_BITS=1, WAY_BITS=1, all lines invalid, flush_valid=1 -> flush_done exactly 10 cycles after acceptance; evict_valid never asserted.
REQ-023 flush_all=0; lines (0,0) hprot=1 dirty=1 and (1,1) hprot=0; evict_ready=1; ack 3 cycles after each eviction -> exactly one eviction, set=0 way=0 dirty=1, one inv_wr_en; flush_done only after the ack.
REQ-024 MAX_OUT=2, all 4 lines valid, flush_all=1, no acks -> 2 handshakes, then evict_valid=0; one ack_valid -> third eviction follows; flush_done only after 4 acks.
REQ-025 stall=1 held 5 cycles in READ -> lmem_rd_en stays 0 for those 5 cycles; walk completes with completion delayed by exactly 5 cycles.
REQ-026 ack_valid while outstanding=0 in IDLE -> ack_err=1; next accepted flush clears it; rst mid-ISSUE -> next cycle busy=0, evict_valid=0, outstanding=0.
